// File: rtl/disp_scheduler.sv
// Time-shares a 4-digit seven-segment display between NSRC debug sources.
// Each round picks a source (auto round-robin over enabled sources, or a manual index),
// converts its binary value to BCD with a sequential double-dabble, commits the result
// and holds it for a dwell period before moving on.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   src_val    packed source values, source k = src_val[k*W +: W]
//   src_en     per-source eligibility for auto rotation
//   man_mode   1 = show man_sel, 0 = auto round-robin
//   man_sel    source index used in manual mode
//   hold       freeze the current display
//   next       one-cycle pulse, ends the dwell early
//   num        committed binary value
//   bcd        committed BCD {thousands, hundreds, tens, ones}
//   cur_src    index of the committed source
//   bcd_valid  a commit has happened since reset
//   upd        one-cycle pulse on each commit
//   busy       selecting or converting
module disp_scheduler #(
  parameter int unsigned NSRC         = 4,
  parameter int unsigned W            = 13,
  parameter int unsigned DWELL_CYCLES = 100000000,
  parameter int unsigned CNT_W        = 27,
  localparam int unsigned SelW        = $clog2(NSRC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NSRC*W-1:0]   src_val,
  input  logic [NSRC-1:0]     src_en,
  input  logic                man_mode,
  input  logic [SelW-1:0]     man_sel,
  input  logic                hold,
  input  logic                next,
  output logic [W-1:0]        num,
  output logic [15:0]         bcd,
  output logic [SelW-1:0]     cur_src,
  output logic                bcd_valid,
  output logic                upd,
  output logic                busy
);

  localparam int unsigned IterW = $clog2(W + 1);
  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IterW-1:0] IterLast  = IterW'(W - 1);

  typedef enum logic [1:0] {StSelect, StConv, StShow} state_e;

  state_e            state_q, state_d;
  logic [SelW-1:0]   ptr_q;
  logic [CNT_W-1:0]  dwell_q;
  logic [IterW-1:0]  iter_q;
  logic [W-1:0]      shift_q;
  logic [15:0]       scratch_q;
  logic [W-1:0]      cap_q;
  logic [W-1:0]      num_q;
  logic [15:0]       bcd_q;
  logic [SelW-1:0]   cur_src_q;
  logic              valid_q;
  logic              upd_q;

  logic              iter_last;
  logic              dwell_last;
  logic [SelW-1:0]   sel_ptr;
  logic [W-1:0]      sel_val;
  logic [15:0]       scr_adj;
  logic [15:0]       scr_step;
  logic [W-1:0]      shift_step;

  assign iter_last  = (iter_q == IterLast);
  assign dwell_last = (dwell_q == DwellLast);

  // Source selection. Auto search starts at ptr+1 and wraps; i == NSRC lands back on ptr,
  // so a lone enabled source keeps being picked.
  always_comb begin
    logic              found;
    logic [SelW-1:0]   idx;
    found   = 1'b0;
    idx     = '0;
    sel_ptr = ptr_q;
    if (man_mode) begin
      sel_ptr = man_sel;
      found   = 1'b1;
    end else begin
      for (int unsigned i = 1; i <= NSRC; i++) begin
        idx = ptr_q + SelW'(i);
        if (!found && src_en[idx]) begin
          found   = 1'b1;
          sel_ptr = idx;
        end
      end
    end
    sel_val = found ? src_val[int'(sel_ptr) * int'(W) +: W] : '0;
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift {scratch, shift} left.
  always_comb begin
    scr_adj = scratch_q;
    for (int n = 0; n < 4; n++) begin
      if (scr_adj[4*n +: 4] >= 4'd5) begin
        scr_adj[4*n +: 4] = scr_adj[4*n +: 4] + 4'd3;
      end
    end
    {scr_step, shift_step} = {scr_adj, shift_q} << 1;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StSelect;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSelect: state_d = StConv;
      StConv:   if (iter_last) state_d = StShow;
      StShow:   if (!hold && (dwell_last || next)) state_d = StSelect;
      default:  state_d = StSelect;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != StShow);
  end

  // Datapath and committed outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= SelW'(NSRC - 1);
      dwell_q   <= '0;
      iter_q    <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      cap_q     <= '0;
      num_q     <= '0;
      bcd_q     <= '0;
      cur_src_q <= '0;
      valid_q   <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      unique case (state_q)
        StSelect: begin
          ptr_q     <= sel_ptr;
          shift_q   <= sel_val;
          cap_q     <= sel_val;
          scratch_q <= '0;
          iter_q    <= '0;
        end
        StConv: begin
          shift_q   <= shift_step;
          scratch_q <= scr_step;
          iter_q    <= iter_q + 1'b1;
          if (iter_last) begin
            bcd_q     <= scr_step;
            num_q     <= cap_q;
            cur_src_q <= ptr_q;
            upd_q     <= 1'b1;
            valid_q   <= 1'b1;
            dwell_q   <= '0;
          end
        end
        StShow: begin
          if (!hold) dwell_q <= dwell_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign num       = num_q;
  assign bcd       = bcd_q;
  assign cur_src   = cur_src_q;
  assign bcd_valid = valid_q;
  assign upd       = upd_q;

endmodule

// File: tb/tb_disp_scheduler.sv
module tb_disp_scheduler;

  localparam int unsigned NSRC  = 4;
  localparam int unsigned W     = 13;
  localparam int unsigned DWELL = 4;
  localparam int unsigned CNTW  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NSRC*W-1:0] src_val;
  logic [NSRC-1:0]   src_en;
  logic              man_mode;
  logic [1:0]        man_sel;
  logic              hold;
  logic              next;
  logic [W-1:0]      num;
  logic [15:0]       bcd;
  logic [1:0]        cur_src;
  logic              bcd_valid;
  logic              upd;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  disp_scheduler #(
    .NSRC(NSRC), .W(W), .DWELL_CYCLES(DWELL), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .src_val(src_val), .src_en(src_en), .man_mode(man_mode),
    .man_sel(man_sel), .hold(hold), .next(next), .num(num), .bcd(bcd), .cur_src(cur_src),
    .bcd_valid(bcd_valid), .upd(upd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until upd is seen; n = ticks taken, or -1 on timeout.
  task automatic wait_upd(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (upd !== 1'b1 && n < max);
    if (upd !== 1'b1) n = -1;
  endtask

  task automatic set_src(input int k, input logic [W-1:0] v);
    src_val[k*W +: W] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; src_val = '0; src_en = 4'b1111; man_mode = 1'b0; man_sel = 2'd0;
    hold = 1'b0; next = 1'b0;
    set_src(0, 13'd0); set_src(1, 13'd1234); set_src(2, 13'd8191); set_src(3, 13'd42);
    tick(); tick(); tick();
    checks++; if (num !== 13'd0) begin failures++; $display("FAIL reset_num got=%0d exp=0", num); end
    checks++; if (bcd !== 16'h0) begin failures++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
    checks++; if (cur_src !== 2'd0) begin failures++; $display("FAIL reset_cur_src got=%0d exp=0", cur_src); end
    checks++; if (bcd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bcd_valid); end
    checks++; if (upd !== 1'b0) begin failures++; $display("FAIL reset_upd got=%b exp=0", upd); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
  endtask

  task automatic test_auto_rotation();
    logic [1:0]  exp_src [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] exp_bcd [5] = '{16'h0000, 16'h1234, 16'h8191, 16'h0042, 16'h0000};
    logic [12:0] exp_num [5] = '{13'd0, 13'd1234, 13'd8191, 13'd42, 13'd0};
    int n;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_upd(40, n);
      checks++; if (n !== ((i == 0) ? 14 : 18)) begin
        failures++; $display("FAIL auto_interval[%0d] got=%0d exp=%0d", i, n, (i == 0) ? 14 : 18);
      end
      checks++; if (cur_src !== exp_src[i]) begin
        failures++; $display("FAIL auto_src[%0d] got=%0d exp=%0d", i, cur_src, exp_src[i]);
      end
      checks++; if (bcd !== exp_bcd[i]) begin
        failures++; $display("FAIL auto_bcd[%0d] got=%h exp=%h", i, bcd, exp_bcd[i]);
      end
      checks++; if (num !== exp_num[i]) begin
        failures++; $display("FAIL auto_num[%0d] got=%0d exp=%0d", i, num, exp_num[i]);
      end
      checks++; if (bcd_valid !== 1'b1 || busy !== 1'b0) begin
        failures++; $display("FAIL auto_flags[%0d] got valid=%b busy=%b exp valid=1 busy=0", i, bcd_valid, busy);
      end
    end
  endtask

  task automatic test_sparse_enable();
    logic [1:0]  exp_src [3] = '{2'd2, 2'd0, 2'd2};
    logic [15:0] exp_bcd [3] = '{16'h8191, 16'h0000, 16'h8191};
    int n;
    src_en = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      wait_upd(40, n);
      checks++; if (n !== 18) begin failures++; $display("FAIL sparse_interval[%0d] got=%0d exp=18", i, n); end
      checks++; if (cur_src !== exp_src[i]) begin
        failures++; $display("FAIL sparse_src[%0d] got=%0d exp=%0d", i, cur_src, exp_src[i]);
      end
      checks++; if (bcd !== exp_bcd[i]) begin
        failures++; $display("FAIL sparse_bcd[%0d] got=%h exp=%h", i, bcd, exp_bcd[i]);
      end
    end
  endtask

  task automatic test_none_enabled();
    int n;
    src_en = 4'b0000;
    wait_upd(40, n);
    checks++; if (n !== 18) begin failures++; $display("FAIL none_interval got=%0d exp=18", n); end
    checks++; if (cur_src !== 2'd2) begin failures++; $display("FAIL none_src got=%0d exp=2", cur_src); end
    checks++; if (num !== 13'd0) begin failures++; $display("FAIL none_num got=%0d exp=0", num); end
    checks++; if (bcd !== 16'h0) begin failures++; $display("FAIL none_bcd got=%h exp=0000", bcd); end
  endtask

  task automatic test_manual();
    int n;
    man_mode = 1'b1; man_sel = 2'd2; set_src(2, 13'd100);
    wait_upd(40, n);
    checks++; if (cur_src !== 2'd2 || bcd !== 16'h0100 || num !== 13'd100) begin
      failures++; $display("FAIL man_first got src=%0d bcd=%h num=%0d exp src=2 bcd=0100 num=100", cur_src, bcd, num);
    end
    set_src(2, 13'd5000);
    tick(); tick(); tick();
    checks++; if (bcd !== 16'h0100) begin failures++; $display("FAIL man_hold_show got=%h exp=0100", bcd); end
    repeat (5) tick();
    checks++; if (bcd !== 16'h0100 || busy !== 1'b1) begin
      failures++; $display("FAIL man_hold_conv got bcd=%h busy=%b exp bcd=0100 busy=1", bcd, busy);
    end
    wait_upd(40, n);
    checks++; if (n !== 10) begin failures++; $display("FAIL man_interval got=%0d exp=10", n); end
    checks++; if (cur_src !== 2'd2 || bcd !== 16'h5000 || num !== 13'd5000) begin
      failures++; $display("FAIL man_refresh got src=%0d bcd=%h num=%0d exp src=2 bcd=5000 num=5000", cur_src, bcd, num);
    end
  endtask

  task automatic test_hold_next();
    int n;
    int bad = 0;
    man_mode = 1'b0; src_en = 4'b1111; hold = 1'b1;
    for (int i = 0; i < 50; i++) begin
      next = (i % 5 == 0);
      tick();
      if (upd !== 1'b0 || busy !== 1'b0) bad++;
    end
    next = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL hold_frozen got=%0d bad cycles exp=0", bad); end
    hold = 1'b0; next = 1'b1;
    tick();
    next = 1'b0;
    wait_upd(40, n);
    checks++; if (n !== 14) begin failures++; $display("FAIL next_latency got=%0d exp=14", n); end
    checks++; if (cur_src !== 2'd3 || bcd !== 16'h0042) begin
      failures++; $display("FAIL next_advance got src=%0d bcd=%h exp src=3 bcd=0042", cur_src, bcd);
    end
  endtask

  task automatic test_reset_mid_conv();
    int n;
    repeat (10) tick();
    checks++; if (busy !== 1'b1 || bcd !== 16'h0042) begin
      failures++; $display("FAIL pre_reset got busy=%b bcd=%h exp busy=1 bcd=0042", busy, bcd);
    end
    rst = 1'b1;
    tick();
    checks++; if (num !== 13'd0 || bcd !== 16'h0 || bcd_valid !== 1'b0 || upd !== 1'b0) begin
      failures++; $display("FAIL mid_reset got num=%0d bcd=%h valid=%b upd=%b exp all 0", num, bcd, bcd_valid, upd);
    end
    set_src(0, 13'd777);
    rst = 1'b0;
    wait_upd(40, n);
    checks++; if (n !== 14) begin failures++; $display("FAIL post_reset_latency got=%0d exp=14", n); end
    checks++; if (cur_src !== 2'd0 || bcd !== 16'h0777 || num !== 13'd777) begin
      failures++; $display("FAIL post_reset_commit got src=%0d bcd=%h num=%0d exp src=0 bcd=0777 num=777", cur_src, bcd, num);
    end
  endtask

  initial begin
    test_reset();
    test_auto_rotation();
    test_sparse_enable();
    test_none_enabled();
    test_manual();
    test_hold_next();
    test_reset_mid_conv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
